// File: rtl/cnn_fp_pkg.sv
// Shared binary32 field layout and constants for the CNN floating-point datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cnn_fp_pkg;

  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MAN_W  = 23;

  // Canonical quiet NaN emitted whenever a window saw any NaN.
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [FP32_SIGN_W-1:0] sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MAN_W-1:0]  man;
  } fp32_t;

endpackage

// File: rtl/fp32_gt_cmp.sv
// Sign-magnitude "a strictly greater than b" compare for binary32, plus NaN detect on a.
// Latency: combinational.
// Backpressure: not applicable.
module fp32_gt_cmp
  import cnn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        a_is_nan
);

  fp32_t       fa;
  fp32_t       fb;
  logic [30:0] mag_a;
  logic [30:0] mag_b;

  assign fa    = a;
  assign fb    = b;
  assign mag_a = {fa.exp, fa.man};
  assign mag_b = {fb.exp, fb.man};

  // NaN: all-ones exponent with a non-zero mantissa.
  assign a_is_nan = (fa.exp == '1) && (fa.man != '0);

  // Zeros of either sign are equal; otherwise sign decides, then magnitude
  // (reversed for negatives). Denormals and infinities fall out naturally.
  always_comb begin
    a_gt_b = 1'b0;
    if ((mag_a == '0) && (mag_b == '0)) begin
      a_gt_b = 1'b0;
    end else if (!fa.sign[0] && fb.sign[0]) begin
      a_gt_b = 1'b1;
    end else if (fa.sign[0] && !fb.sign[0]) begin
      a_gt_b = 1'b0;
    end else if (!fa.sign[0]) begin
      a_gt_b = mag_a > mag_b;
    end else begin
      a_gt_b = mag_a < mag_b;
    end
  end

endmodule

// File: rtl/tanh_max_pool.sv
// Streaming 1-D max pool over POOL_SIZE binary32 samples (or shorter when flushed);
// optional out_idx argmax port when TANH_MAX_POOL_ARGMAX_EN is defined.
// Latency: result valid 1 cycle after the closing handshake.
// Backpressure: in_ready = ~out_valid | out_ready; a held result stalls input and flush.
module tanh_max_pool
  import cnn_fp_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int POOL_SIZE  = 4,
  localparam int CNT_W      = $clog2(POOL_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
`ifdef TANH_MAX_POOL_ARGMAX_EN
  output logic [CNT_W-1:0]      out_idx,
`endif
  input  logic                  out_ready
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("tanh_max_pool: only DATA_WIDTH=32 (binary32) is supported");
  end
  if ((POOL_SIZE < 2) || (POOL_SIZE > 256)) begin : g_bad_pool
    $error("tanh_max_pool: POOL_SIZE must be in 2..256");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(POOL_SIZE - 1);

  logic [1:0]       rst_pipe;
  logic             rst_n;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      max_q;
  logic             sticky_q;
  logic [31:0]      max_n;
  logic             sticky_n;
  logic             accept;
  logic             first;
  logic             close;
  logic             in_gt;
  logic             in_nan;
`ifdef TANH_MAX_POOL_ARGMAX_EN
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_n;
`endif

  // Assert asynchronously, release two clocks after the external reset lifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign first    = (cnt_q == '0);

  fp32_gt_cmp u_cmp (
    .a        (in_data),
    .b        (max_q),
    .a_gt_b   (in_gt),
    .a_is_nan (in_nan)
  );

  // Window state after folding in this cycle's accepted sample (if any).
  always_comb begin
    max_n    = max_q;
    sticky_n = sticky_q;
`ifdef TANH_MAX_POOL_ARGMAX_EN
    idx_n    = idx_q;
`endif
    if (accept) begin
      if (first) begin
        max_n    = in_data;
        sticky_n = in_nan;
`ifdef TANH_MAX_POOL_ARGMAX_EN
        idx_n    = '0;
`endif
      end else if (in_nan && !sticky_q) begin
        sticky_n = 1'b1;
`ifdef TANH_MAX_POOL_ARGMAX_EN
        idx_n    = cnt_q;
`endif
      end else if (!sticky_q && in_gt) begin
        max_n    = in_data;
`ifdef TANH_MAX_POOL_ARGMAX_EN
        idx_n    = cnt_q;
`endif
      end
    end
  end

  // A window closes on its last sample, or on flush when it holds anything
  // (including a sample accepted this same cycle); flush needs in_ready.
  assign close = (accept && (cnt_q == LAST)) ||
                 (flush && in_ready && (!first || accept));

  // Running window: counter, max, sticky NaN flag (and argmax position).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      max_q    <= '0;
      sticky_q <= 1'b0;
`ifdef TANH_MAX_POOL_ARGMAX_EN
      idx_q    <= '0;
`endif
    end else if (close) begin
      cnt_q    <= '0;
      max_q    <= max_n;
      sticky_q <= 1'b0;
`ifdef TANH_MAX_POOL_ARGMAX_EN
      idx_q    <= '0;
`endif
    end else if (accept) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      max_q    <= max_n;
      sticky_q <= sticky_n;
`ifdef TANH_MAX_POOL_ARGMAX_EN
      idx_q    <= idx_n;
`endif
    end
  end

  // Single-entry output register; a close can only happen when it is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef TANH_MAX_POOL_ARGMAX_EN
      out_idx   <= '0;
`endif
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= sticky_n ? FP32_QNAN : max_n;
`ifdef TANH_MAX_POOL_ARGMAX_EN
      out_idx   <= idx_n;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tanh_max_pool.sv
// Bench for tanh_max_pool: directed windows plus randomized streaming against
// an ordered-key reference model; out_idx checked when TANH_MAX_POOL_ARGMAX_EN is set.
module tb_tanh_max_pool;

  localparam int POOL = 4;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef TANH_MAX_POOL_ARGMAX_EN
  logic [1:0]  out_idx;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tanh_max_pool #(.DATA_WIDTH(32), .POOL_SIZE(POOL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef TANH_MAX_POOL_ARGMAX_EN
    .out_idx   (out_idx),
`endif
    .out_ready (out_ready)
  );

  // ---------------- reference model ----------------
  logic [31:0] win[$];
  logic [31:0] exp_d[$];
  int          exp_i[$];
  logic        hold_active = 1'b0;
  logic [31:0] hold_dat;

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  // Signed ordering key: zeros of both signs map to 0, negatives below.
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    if (m == 0) return 0;
    return v[31] ? -m : m;
  endfunction

  task automatic model_close();
    int best;
    int nidx;
    bit seen_nan;
    best = 0;
    nidx = 0;
    seen_nan = 0;
    foreach (win[i]) begin
      if (is_nan(win[i]) && !seen_nan) begin
        seen_nan = 1;
        nidx = i;
      end
    end
    if (seen_nan) begin
      exp_d.push_back(QNAN);
      exp_i.push_back(nidx);
    end else begin
      for (int i = 1; i < win.size(); i++)
        if (fkey(win[i]) > fkey(win[best])) best = i;
      exp_d.push_back(win[best]);
      exp_i.push_back(best);
    end
    win.delete();
  endtask

  // Monitor/model: inputs are driven just after posedge, so everything is stable here.
  always @(negedge clk) begin
    logic [31:0] ed;
    int          ei;
    bit          acc;
    if (!reset) begin
      win.delete();
      exp_d.delete();
      exp_i.delete();
      hold_active = 1'b0;
    end else begin
      if (hold_active) begin
        checks++;
        if (!out_valid || out_data !== hold_dat) begin
          failures++;
          $display("FAIL hold_stable: out_valid=%0b out_data=%h required valid=1 data=%h",
                   out_valid, out_data, hold_dat);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: out_data=%h required no output", out_data);
        end else begin
          ed = exp_d.pop_front();
          ei = exp_i.pop_front();
          if (out_data !== ed) begin
            failures++;
            $display("FAIL model_data: out_data=%h required %h", out_data, ed);
          end
`ifdef TANH_MAX_POOL_ARGMAX_EN
          checks++;
          if (int'(out_idx) != ei) begin
            failures++;
            $display("FAIL model_idx: out_idx=%0d required %0d", out_idx, ei);
          end
`endif
        end
      end
      hold_active = out_valid && !out_ready;
      hold_dat = out_data;
      acc = in_valid && in_ready;
      if (acc) win.push_back(in_data);
      if ((acc && win.size() == POOL) || (flush && in_ready && win.size() > 0))
        model_close();
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] d, input logic f);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data = d;
    flush = f;
    ok = 0;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    bit ok;
    int n;
    flush = 1'b1;
    ok = 0;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      failures++;
      $display("FAIL flush_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send a full window back-to-back and check the result one cycle later.
  task automatic window_check(input string name, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] exp_v, input int exp_idx);
    send(w0, 1'b0);
    send(w1, 1'b0);
    send(w2, 1'b0);
    send(w3, 1'b0);
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== exp_v) begin
      failures++;
      $display("FAIL %s: out_valid=%0b out_data=%h required valid=1 data=%h",
               name, out_valid, out_data, exp_v);
    end
`ifdef TANH_MAX_POOL_ARGMAX_EN
    checks++;
    if (int'(out_idx) != exp_idx) begin
      failures++;
      $display("FAIL %s_idx: out_idx=%0d required %0d", name, out_idx, exp_idx);
    end
`else
    if (exp_idx < 0) $display("note: negative index for %s", name);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%0b out_data=%h required 0 / 00000000",
               out_valid, out_data);
    end
    idle(3);
    reset = 1'b1;
    idle(4);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%0b data=%h in_ready=%0b required 0/00000000/1",
               out_valid, out_data, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    window_check("basic_max", 32'hBEEC9A9E, 32'h3EEC9A9E, 32'h3F76CA83, 32'hBF76CA83,
                 32'h3F76CA83, 2);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse: out_valid=%0b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    window_check("all_negative", 32'hBF76CA83, 32'hBF000000, 32'hBEEC9A9E, 32'hBF400000,
                 32'hBEEC9A9E, 2);
    window_check("zero_tie", 32'h80000000, 32'h00000000, 32'hBF000000, 32'h80000000,
                 32'h80000000, 0);
    window_check("inf_denorm", 32'h00000001, 32'hFF800000, 32'h7F800000, 32'h7F7FFFFF,
                 32'h7F800000, 2);
  endtask

  task automatic test_nan();
    window_check("nan_window", 32'h3F000000, 32'h7FA00001, 32'h3F76CA83, 32'h00000000,
                 QNAN, 1);
    window_check("after_nan", 32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000,
                 32'h3E800000, 0);
  endtask

  task automatic test_back_to_back();
    // Two windows with no gap: second result must follow four cycles after the first.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h3F000000 + 32'(i), 1'b0);
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== 32'h3F000007) begin
      failures++;
      $display("FAIL back_to_back: out_valid=%0b out_data=%h required 1 / 3F000007",
               out_valid, out_data);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h3E000000, 1'b0);
    send(32'h3F000000, 1'b0);
    send(32'h3E800000, 1'b0);
    send(32'h3D000000, 1'b0);
    in_valid = 1'b1;
    in_data = 32'h3F400000;
    idle(5);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || !out_valid || out_data !== 32'h3F000000) begin
      failures++;
      $display("FAIL backpressure_hold: in_ready=%0b valid=%0b data=%h required 0/1/3F000000",
               in_ready, out_valid, out_data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h3F400000, 1'b0);
    send(32'hBF400000, 1'b0);
    send(32'h3F400000, 1'b0);
    send(32'h3E000000, 1'b0);
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== 32'h3F400000) begin
      failures++;
      $display("FAIL backpressure_second: valid=%0b data=%h required 1 / 3F400000",
               out_valid, out_data);
    end
    idle(2);
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(32'h3E800000, 1'b0);
    send(32'h3F000000, 1'b0);
    do_flush();
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== 32'h3F000000) begin
      failures++;
      $display("FAIL flush_partial: valid=%0b data=%h required 1 / 3F000000", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    // Flush on an empty window must produce nothing.
    do_flush();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty: out_valid=%0b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    // Flush together with a sample closes a window that includes it.
    send(32'hBF000000, 1'b0);
    send(32'h3C000000, 1'b1);
    @(negedge clk);
    checks++;
    if (!out_valid || out_data !== 32'h3C000000) begin
      failures++;
      $display("FAIL flush_with_sample: valid=%0b data=%h required 1 / 3C000000",
               out_valid, out_data);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    send(32'h7F000000, 1'b0);
    send(32'h7F000000, 1'b0);
    send(32'h7FA00000, 1'b0);
    apply_reset();
    window_check("post_reset", 32'hBE000000, 32'hBF000000, 32'hBD000000, 32'hBE800000,
                 32'hBD000000, 2);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: r = {r[31], 31'h0};
      1: r = {r[31], 8'hFF, (r[22:0] == 0) ? 23'h1 : r[22:0]};
      2: r = {r[31], 8'hFF, 23'h0};
      3: r = {r[31], 8'h00, r[22:0]};
      4: r = {r[31], 8'h7E, r[22:20], 20'h0};
      default: r = {r[31], 8'(8'h70 + r[27:24]), r[22:0]};
    endcase
    return r;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = rand_fp();
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    do_flush();
    idle(4);
    checks++;
    if (exp_d.size() != 0) begin
      failures++;
      $display("FAIL random_drain: pending=%0d required 0", exp_d.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
